// File: rtl/data_memory_sized.sv
// Byte-addressed RV32I data memory: sized/signed loads, byte-enable stores,
// 1-cycle registered reads, misalign/range checks and a post-reset clear sequencer.
//
// state   | meaning
// S_CLEAR | zeroing one word per cycle, requests dropped, busy=1
// S_IDLE  | accepting one load or store per cycle
module data_memory_sized #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [31:0]           i_write_data,
  input  logic                  i_write_enable,
  input  logic                  i_read_enable,
  input  logic [2:0]            i_funct3,
  output logic                  o_busy,
  output logic [31:0]           o_read_data,
  output logic                  o_read_valid,
  output logic                  o_misaligned,
  output logic                  o_fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   r_read_data;
  logic          r_read_valid;
  logic          r_misaligned;
  logic          r_fault;

  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_in_range;
  logic          w_illegal;
  logic          w_fault;
  logic          w_misal;
  logic          w_ok;
  logic          w_accept;
  logic          w_do_store;
  logic          w_do_load;

  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [3:0]    w_mem_be;
  logic [31:0]   w_mem_wd;

  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_val;

  assign w_idx      = i_address[AW+1:2];
  assign w_lane     = i_address[1:0];
  assign w_in_range = ({1'b0, i_address} < (ADDR_WIDTH+1)'(4 * DEPTH));

  // Unsigned sizes are load-only; 011/11x are never legal.
  always_comb begin
    w_illegal = 1'b1;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = i_write_enable;
      default:                w_illegal = 1'b1;
    endcase
  end

  assign w_fault    = w_illegal | ~w_in_range;
  assign w_misal    = ~w_fault &
                      (((i_funct3[1:0] == 2'b01) & w_lane[0]) |
                       ((i_funct3[1:0] == 2'b10) & (w_lane != 2'b00)));
  assign w_ok       = ~w_fault & ~w_misal;
  assign w_accept   = (r_state == S_IDLE) & ~i_reset & (i_write_enable | i_read_enable);
  assign w_do_store = w_accept & i_write_enable & w_ok;
  assign w_do_load  = w_accept & i_read_enable & ~i_write_enable;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_mem_we      = 1'b0;
    w_mem_idx     = w_idx;
    w_mem_be      = 4'b0000;
    w_mem_wd      = 32'h0;
    case (r_state)
      S_CLEAR: begin
        w_mem_we      = ~i_reset;
        w_mem_idx     = r_clr_cnt;
        w_mem_be      = 4'b1111;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == AW'(DEPTH - 1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_do_store) begin
          w_mem_we = 1'b1;
          case (i_funct3[1:0])
            2'b00: begin
              w_mem_be = 4'b0001 << w_lane;
              w_mem_wd = {4{i_write_data[7:0]}};
            end
            2'b01: begin
              w_mem_be = w_lane[1] ? 4'b1100 : 4'b0011;
              w_mem_wd = {2{i_write_data[15:0]}};
            end
            default: begin
              w_mem_be = 4'b1111;
              w_mem_wd = i_write_data;
            end
          endcase
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_we && w_mem_be[b]) begin
        r_mem[w_mem_idx][b*8 +: 8] <= w_mem_wd[b*8 +: 8];
      end
    end
  end

  // Array read happens before the same-edge write lands, giving read-first behaviour.
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load_val = w_word;
    case (i_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h0, w_byte};
      3'b101:  w_load_val = {16'h0, w_half};
      default: w_load_val = w_word;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_read_data  <= 32'h0;
      r_read_valid <= 1'b0;
      r_misaligned <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_read_valid <= w_do_load;
      r_misaligned <= w_accept & w_misal;
      r_fault      <= w_accept & w_fault;
      if (w_do_load) begin
        r_read_data <= w_ok ? w_load_val : 32'h0;
      end
    end
  end

  assign o_busy       = (r_state == S_CLEAR);
  assign o_read_data  = r_read_data;
  assign o_read_valid = r_read_valid;
  assign o_misaligned = r_misaligned;
  assign o_fault      = r_fault;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboarded random/directed bench for data_memory_sized against a byte-array
// reference model; a monitor pops expected responses whenever the DUT responds.
module tb_data_memory_sized;

  localparam int DEPTH = 512;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [31:0]   write_data;
  logic          write_enable;
  logic          read_enable;
  logic [2:0]    funct3;
  logic          busy;
  logic [31:0]   read_data;
  logic          read_valid;
  logic          misaligned;
  logic          fault;

  always #5 clk = ~clk;

  data_memory_sized #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_address      (address),
    .i_write_data   (write_data),
    .i_write_enable (write_enable),
    .i_read_enable  (read_enable),
    .i_funct3       (funct3),
    .o_busy         (busy),
    .o_read_data    (read_data),
    .o_read_valid   (read_valid),
    .o_misaligned   (misaligned),
    .o_fault        (fault)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        mis;
    logic        flt;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model [0:4*DEPTH-1];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4*DEPTH; i++) model[i] = 8'h00;
  endtask

  // Drive one request for the coming edge, then record what it must produce.
  task automatic req(input logic we_i, input logic re_i, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          size;
    logic        illegal, flt, mis;
    logic [31:0] v;
    @(negedge clk);
    write_enable = we_i;
    read_enable  = re_i;
    funct3       = f3;
    address      = addr;
    write_data   = wd;
    @(posedge clk);
    illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we_i && f3[2]);
    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    flt     = illegal || !(addr < 32'(4*DEPTH));
    mis     = !flt && ((addr % size) != 0);
    if (we_i) begin
      if (!flt && !mis) begin
        for (int i = 0; i < size; i++) model[addr + i] = wd[8*i +: 8];
      end
      if (flt || mis) begin
        e = '{valid: 1'b0, data: 32'h0, mis: mis, flt: flt};
        q.push_back(e);
      end
    end else if (re_i) begin
      v = 32'h0;
      if (!flt && !mis) begin
        for (int i = 0; i < size; i++) v[8*i +: 8] = model[addr + i];
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      end
      e = '{valid: 1'b1, data: v, mis: mis, flt: flt};
      q.push_back(e);
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Entered at the negedge where reset was just dropped; counts busy cycles.
  task automatic wait_clear(input bit noisy);
    int n = 0;
    while (busy === 1'b1 && n < 2*DEPTH + 8) begin
      n++;
      if (noisy) begin
        write_enable = 1'b1;
        read_enable  = 1'($urandom_range(0, 1));
        funct3       = 3'b010;
        address      = {$urandom_range(0, DEPTH-1), 2'b00};
        write_data   = $urandom | 32'h1;
      end
      @(negedge clk);
    end
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check("clear_busy_cycles", n, DEPTH);
    model_zero();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && (read_valid || misaligned || fault)) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got v=%b d=%h m=%b f=%b want no response",
                   read_valid, read_data, misaligned, fault);
        end else begin
          e = q.pop_front();
          if (read_valid !== e.valid || misaligned !== e.mis || fault !== e.flt ||
              (e.valid && read_data !== e.data)) begin
            bad++;
            $display("FAIL response: got v=%b d=%h m=%b f=%b want v=%b d=%h m=%b f=%b",
                     read_valid, read_data, misaligned, fault, e.valid, e.data, e.mis, e.flt);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [2:0]  legal3 [5];
    int          kind;
    logic [2:0]  f3;
    logic [31:0] a;
    legal3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
    funct3 = 3'b000; address = '0; write_data = '0;
    model_zero();
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_read_data", read_data, 32'h0);
    check("reset_read_valid", 32'(read_valid), 32'd0);
    check("reset_misaligned", 32'(misaligned), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    wait_clear(1'b1);

    for (int i = 0; i < DEPTH; i++) req(1'b0, 1'b1, 3'b010, 32'(i*4), 32'h0);

    req(1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF);
    req(1'b1, 1'b0, 3'b000, 32'h11, 32'h00000011);
    req(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    req(1'b0, 1'b1, 3'b000, 32'h13, 32'h0);
    req(1'b0, 1'b1, 3'b100, 32'h13, 32'h0);
    req(1'b1, 1'b0, 3'b001, 32'h22, 32'h00008001);
    req(1'b0, 1'b1, 3'b001, 32'h22, 32'h0);
    req(1'b0, 1'b1, 3'b101, 32'h22, 32'h0);
    req(1'b0, 1'b1, 3'b010, 32'h20, 32'h0);

    req(1'b0, 1'b1, 3'b010, 32'h06, 32'h0);
    req(1'b1, 1'b0, 3'b001, 32'h05, 32'hFFFF);
    req(1'b0, 1'b1, 3'b010, 32'h04, 32'h0);
    req(1'b1, 1'b0, 3'b010, 32'h800, 32'h12345678);
    req(1'b0, 1'b1, 3'b011, 32'h10, 32'h0);
    req(1'b1, 1'b0, 3'b100, 32'h30, 32'hAA);
    req(1'b0, 1'b1, 3'b010, 32'h30, 32'h0);
    req(1'b0, 1'b1, 3'b001, 32'h7FF, 32'h0);
    req(1'b0, 1'b1, 3'b010, 32'h7FC, 32'h0);

    req(1'b1, 1'b1, 3'b010, 32'h40, 32'h5);
    req(1'b0, 1'b1, 3'b010, 32'h40, 32'h0);
    go_idle(2);

    for (int n = 0; n < 1500; n++) begin
      kind = $urandom_range(0, 9);
      f3   = ($urandom_range(0, 4) != 0) ? legal3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a    = $urandom_range(0, 4*DEPTH + 15);
      if ($urandom_range(0, 9) < 7) a = a & ~32'((f3[1:0] == 2'b00) ? 0 : (f3[1:0] == 2'b01) ? 1 : 3);
      if (kind == 0)      go_idle(0);
      else if (kind <= 4) req(1'b0, 1'b1, f3, a, $urandom);
      else if (kind <= 8) req(1'b1, 1'b0, f3, a, $urandom);
      else                req(1'b1, 1'b1, f3, a, $urandom);
    end
    go_idle(3);
    check("queue_drained_random", q.size(), 0);

    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midclear_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    wait_clear(1'b0);
    for (int i = 0; i < 16; i++) req(1'b0, 1'b1, 3'b010, 32'($urandom_range(0, DEPTH-1) * 4), 32'h0);
    req(1'b1, 1'b0, 3'b010, 32'h44, 32'hCAFEF00D);
    go_idle(2);

    @(negedge clk);
    reset        = 1'b1;
    read_enable  = 1'b1;
    funct3       = 3'b010;
    address      = 32'h44;
    @(negedge clk);
    check("reset_with_load_valid", 32'(read_valid), 32'd0);
    check("reset_with_load_data", read_data, 32'h0);
    read_enable = 1'b0;
    reset       = 1'b0;
    wait_clear(1'b0);
    req(1'b0, 1'b1, 3'b010, 32'h44, 32'h0);
    req(1'b1, 1'b0, 3'b000, 32'h47, 32'h80);
    req(1'b0, 1'b1, 3'b000, 32'h47, 32'h0);
    req(1'b0, 1'b1, 3'b101, 32'h46, 32'h0);
    go_idle(3);
    check("queue_drained_final", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Parametrised byte-addressed data memory for the RISC-V core's load/store path, replacing the fixed 512-word, word-only memory. Supports RV32I load/store sizes (byte, halfword, word, signed/unsigned) with per-byte write enables. Reads are synchronous with one-cycle latency. The block also provides misalignment and out-of-range detection and a hardware clear sequencer that zeroes the array one word per cycle after reset, so reset no longer needs a single-cycle, full-array clear.

## Interface
- DEPTH, 512, number of 32-bit words; must be a power of two, ≥ 4
- ADDR_WIDTH, 32, width of the byte address input
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- address  input  ADDR_WIDTH  byte address of the access
- write_data  input  32  store data; value in low-order bytes for SB/SH
- write_enable  input  1  store request, sampled at posedge
- read_enable  input  1  load request, sampled at posedge
- funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- busy  output  1  clear sequence in progress; requests ignored
- read_data  output  32  load result, extended per funct3
- read_valid  output  1  read_data valid this cycle
- misaligned  output  1  previous accepted request was misaligned
- fault  output  1  previous accepted request was out of range or had an illegal funct3

## Operation
- Word index = address[log2(DEPTH)+1:2]. Byte lane = address[1:0].
- A request is in range iff address < 4*DEPTH.
- States: CLEAR, IDLE.
  - While reset is high: state=CLEAR, clear counter=0, busy=1, all other outputs 0.
  - In CLEAR with reset low: write 0 to word[counter] and increment the counter.
  - After word DEPTH-1 is written, go to IDLE.
- A request is accepted only in IDLE with busy=0. Requests during CLEAR are dropped with no response.
- Alignment rules:
  - H/HU requires address[0]=0.
  - W requires address[1:0]=00.
  - B/BU are always aligned.
- Illegal funct3 (011, 110, 111) sets fault; no array access occurs.
- Store SB: write write_data[7:0] to the addressed lane.
- Store SH: write write_data[15:0] to lanes {a1,0},{a1,1}.
- Store SW: write all 4 lanes.
- Stores never modify the other lanes. Stores use funct3 000/001/010 only; 100/101 on a store is illegal.
- Load B/H: sign-extend the selected byte/halfword to 32 bits. Load BU/HU: zero-extend. Load W: full word.
- Misaligned, out-of-range, or illegal request:
  - No write.
  - If it was a load: read_valid=1, read_data=0.
  - The corresponding flag is pulsed. Flags are mutually exclusive, with priority fault > misaligned.
- write_enable and read_enable both high: the write is performed, no load response, read_valid=0.
- Loads are read-first: a load to a word written in the same cycle returns the pre-write contents.

## Timing
- Reset values: busy=1, read_data=0, read_valid=0, misaligned=0, fault=0.
- Clear duration: busy stays high for exactly DEPTH cycles after the first posedge with reset low. The first request is accepted on the edge at which busy=0 is observed.
- Load latency is 1 cycle:
  - Request sampled at edge N.
  - read_data, read_valid, and flags are registered at edge N and valid until edge N+1.
  - read_valid is a single-cycle pulse per load.
- Store latency: array updated at edge N. A load sampled at edge N+1 sees the new data.
- Flags for a store pulse for one cycle after edge N. read_valid stays 0.
- When no load is accepted, read_data holds its last value and read_valid=0.
- Reset mid-clear or mid-access:
  - The counter returns to 0 and any pending response is cancelled.
  - Outputs take reset values at the next edge.
  - A full clear follows reset release.
- Back-to-back requests every cycle are supported; throughput is 1 access/cycle.

## Test plan
- Reset then release, DEPTH=512 → busy high exactly 512 cycles. A LW of every word 0..511 (addresses 0..0x7FC) returns 0 with read_valid one cycle after each request.
- SW 0xDEADBEEF @0x10; then SB 0x11 @0x11 → LW @0x10 returns 0xDEAD11EF. LB @0x13 returns 0xFFFFFFDE. LBU @0x13 returns 0x000000DE.
- SH 0x8001 @0x22 → LH @0x22 returns 0xFFFF8001. LHU @0x22 returns 0x00008001. LW @0x20 returns 0x80010000.
- LW @0x06 and SH @0x05 → misaligned pulses; read_data=0 for the load; memory unchanged. SW @0x800 (DEPTH=512) → fault pulses, no write. funct3=011 → fault.
- SW 0x5 @0x40 with read_enable=1 in the same cycle, then LW @0x40 next cycle → no response for the first request; the second returns 0x5.
- Assert reset during cycle 100 of clear, and separately in the cycle a LW is issued → read_valid stays 0. busy runs a full 512 cycles from the new release.
